// File: rtl/bus_scheduler.sv
// Shared-bus sequencer: splits each 1 us CPU cycle into two 4-tick SPI/video slots and an 8-tick CPU phase.
// bus_scheduler_checker holds the protocol assertions and is instantiated alongside the scheduler.
module bus_scheduler #(
   parameter logic VIDEO_EN = 1'b1,
   parameter logic RR_INIT  = 1'b0
) (
   input  logic       clk_16_i,
   input  logic       rst_ni,
   input  logic       spi_valid_i,
   input  logic       spi_rw_ni,
   output logic       spi_ready_o,
   input  logic       vid_req_i,
   output logic       vid_ack_o,
   output logic       clk_cpu_o,
   output logic       cpu_select_o,
   output logic       cpu_enable_o,
   output logic       spi_select_o,
   output logic       vid_select_o,
   output logic       mem_oe_o,
   output logic       mem_we_o,
   output logic       rd_strobe_o,
   output logic [3:0] cycle_o
);

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_SPI  = 2'd1,
      GRANT_VID  = 2'd2
   } grant_t;

   grant_t     grant_r;
   grant_t     grant_nxt_s;
   logic [3:0] cycle_r;
   logic [3:0] cycle_nxt_s;
   logic       rw_r;
   logic       rw_nxt_s;
   logic       rr_r;
   logic       rr_nxt_s;
   logic       started_r;
   logic       started_nxt_s;
   logic       slot_start_s;
   logic       arb_ok_s;
   logic       spi_elig_s;
   logic       vid_elig_s;

   logic       clk_cpu_r,    clk_cpu_s;
   logic       cpu_select_r, cpu_select_s;
   logic       cpu_enable_r, cpu_enable_s;
   logic       spi_select_r, spi_select_s;
   logic       vid_select_r, vid_select_s;
   logic       mem_oe_r,     mem_oe_s;
   logic       mem_we_r,     mem_we_s;
   logic       rd_strobe_r,  rd_strobe_s;
   logic       spi_ready_r,  spi_ready_s;
   logic       vid_ack_r,    vid_ack_s;
   logic       slot_read_s;
   logic       owned_s;
   logic [1:0] offset_s;

   // Next-state: tick advance, slot arbitration with re-grant mask, and next output values.
   always_comb begin
      grant_nxt_s   = grant_r;
      rw_nxt_s      = rw_r;
      rr_nxt_s      = rr_r;
      cycle_nxt_s   = cycle_r + 4'd1;
      started_nxt_s = started_r;
      slot_start_s  = (cycle_nxt_s[1:0] == 2'd0) && !cycle_nxt_s[3];
      // Nothing is granted until the first full frame begins after reset.
      arb_ok_s      = started_r || (cycle_nxt_s == 4'd0);
      spi_elig_s    = arb_ok_s && spi_valid_i &&
                      !((cycle_nxt_s == 4'd4) && spi_ready_r);
      vid_elig_s    = arb_ok_s && (VIDEO_EN != 1'b0) && vid_req_i &&
                      !((cycle_nxt_s == 4'd4) && vid_ack_r);

      if (cycle_nxt_s == 4'd0) begin
         started_nxt_s = 1'b1;
      end else begin
         started_nxt_s = started_r;
      end

      if (cycle_nxt_s[3]) begin
         grant_nxt_s = GRANT_NONE;
      end else if (slot_start_s) begin
         case ({spi_elig_s, vid_elig_s})
            2'b10:   grant_nxt_s = GRANT_SPI;
            2'b01:   grant_nxt_s = GRANT_VID;
            2'b11:   grant_nxt_s = rr_r ? GRANT_VID : GRANT_SPI;
            default: grant_nxt_s = GRANT_NONE;
         endcase
         case (grant_nxt_s)
            GRANT_SPI: begin
               rr_nxt_s = 1'b1;
               rw_nxt_s = spi_rw_ni;
            end
            GRANT_VID: begin
               rr_nxt_s = 1'b0;
               rw_nxt_s = 1'b1;
            end
            default: begin
               rr_nxt_s = rr_r;
               rw_nxt_s = 1'b1;
            end
         endcase
      end else begin
         grant_nxt_s = grant_r;
      end

      offset_s     = cycle_nxt_s[1:0];
      owned_s      = (grant_nxt_s != GRANT_NONE);
      slot_read_s  = owned_s && rw_nxt_s;
      spi_select_s = (grant_nxt_s == GRANT_SPI);
      vid_select_s = (grant_nxt_s == GRANT_VID);
      mem_oe_s     = slot_read_s && (offset_s != 2'd0);
      mem_we_s     = spi_select_s && !rw_nxt_s &&
                     ((offset_s == 2'd1) || (offset_s == 2'd2));
      rd_strobe_s  = slot_read_s && (offset_s == 2'd3);
      spi_ready_s  = spi_select_s && (offset_s == 2'd3);
      vid_ack_s    = vid_select_s && (offset_s == 2'd3);
      clk_cpu_s    = cycle_nxt_s[3];
      cpu_select_s = cycle_nxt_s[3];
      cpu_enable_s = cycle_nxt_s[3] && cycle_nxt_s[2];
   end

   // State and output registers; a mid-slot reset drops everything with no completion pulse.
   always_ff @(posedge clk_16_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_r      <= GRANT_NONE;
         cycle_r      <= 4'd0;
         rw_r         <= 1'b1;
         rr_r         <= RR_INIT;
         started_r    <= 1'b0;
         clk_cpu_r    <= 1'b0;
         cpu_select_r <= 1'b0;
         cpu_enable_r <= 1'b0;
         spi_select_r <= 1'b0;
         vid_select_r <= 1'b0;
         mem_oe_r     <= 1'b0;
         mem_we_r     <= 1'b0;
         rd_strobe_r  <= 1'b0;
         spi_ready_r  <= 1'b0;
         vid_ack_r    <= 1'b0;
      end else begin
         grant_r      <= grant_nxt_s;
         cycle_r      <= cycle_nxt_s;
         rw_r         <= rw_nxt_s;
         rr_r         <= rr_nxt_s;
         started_r    <= started_nxt_s;
         clk_cpu_r    <= clk_cpu_s;
         cpu_select_r <= cpu_select_s;
         cpu_enable_r <= cpu_enable_s;
         spi_select_r <= spi_select_s;
         vid_select_r <= vid_select_s;
         mem_oe_r     <= mem_oe_s;
         mem_we_r     <= mem_we_s;
         rd_strobe_r  <= rd_strobe_s;
         spi_ready_r  <= spi_ready_s;
         vid_ack_r    <= vid_ack_s;
      end
   end

   assign cycle_o      = cycle_r;
   assign clk_cpu_o    = clk_cpu_r;
   assign cpu_select_o = cpu_select_r;
   assign cpu_enable_o = cpu_enable_r;
   assign spi_select_o = spi_select_r;
   assign vid_select_o = vid_select_r;
   assign mem_oe_o     = mem_oe_r;
   assign mem_we_o     = mem_we_r;
   assign rd_strobe_o  = rd_strobe_r;
   assign spi_ready_o  = spi_ready_r;
   assign vid_ack_o    = vid_ack_r;

endmodule

module bus_scheduler_checker (
   input logic clk_16_i,
   input logic rst_ni,
   input logic cpu_select_o,
   input logic spi_select_o,
   input logic vid_select_o,
   input logic mem_oe_o,
   input logic mem_we_o,
   input logic spi_ready_o,
   input logic vid_ack_o
);

   a_one_owner: assert property (@(posedge clk_16_i) disable iff (!rst_ni)
      $onehot0({cpu_select_o, spi_select_o, vid_select_o}));

   a_oe_we_excl: assert property (@(posedge clk_16_i) disable iff (!rst_ni)
      !(mem_oe_o && mem_we_o));

   a_ready_owned: assert property (@(posedge clk_16_i) disable iff (!rst_ni)
      (!spi_ready_o || spi_select_o) && (!vid_ack_o || vid_select_o));

endmodule
